dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data RAM of the MEM stage between two requesters: the CPU pipeline (MEM stage) and a debug/loader port (program/data loader, memory inspection).
- CPU has priority. Its accesses pass through combinationally with no added latency.
- The loader uses a req/ack handshake and is served when the CPU is idle. A bounded-wait counter forces a one-cycle CPU stall so the loader cannot starve.

Parameters:
ADDR_W, 14, RAM word-address width (matches 14-bit RAM address)
DATA_W, 32, data word width
MAX_WAIT, 4, consecutive blocked cycles (dbg_req high, CPU busy) before the loader is forced in; range 1..15

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  MEM stage needs RAM this cycle (load or store, not NOP)
cpu_we  in  1  CPU store enable (qualified by cpu_req)
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  ram_rdata passed through
cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold and retry
dbg_req  in  1  loader request; held with dbg_we/addr/wdata stable until dbg_ack
dbg_we  in  1  loader write enable
dbg_addr  in  ADDR_W  loader word address
dbg_wdata  in  DATA_W  loader write data
dbg_rdata  out  DATA_W  registered loader read data, valid while dbg_ack=1, held after
dbg_ack  out  1  one-cycle completion pulse
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data; valid one cycle after the address is presented

Behaviour:
- Reset values: state=S_CPU, wait_cnt=0, dbg_rdata=0, dbg_ack=0. Combinational outputs in reset: cpu_stall=0, ram_we=0.
- States, 2-bit encoding: S_CPU=0, S_DBG_RD=1, S_DBG_ACK=2; encoding 3 goes to S_CPU.
- Grant in S_CPU: dbg_sel = dbg_req && (!cpu_req || wait_cnt==MAX_WAIT). Decided combinationally in the same cycle.
- dbg_sel=1:
  - ram_addr=dbg_addr, ram_wdata=dbg_wdata, ram_we=dbg_we.
  - cpu_stall=cpu_req.
  - next state S_DBG_RD; wait_cnt cleared.
- dbg_sel=0:
  - ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_req&&cpu_we.
  - cpu_stall=0.
  - wait_cnt: +1 when dbg_req&&cpu_req (saturating at MAX_WAIT); 0 when !dbg_req.
- S_DBG_RD:
  - RAM is driven by the CPU exactly as for dbg_sel=0, and the CPU is never stalled.
  - At the clock edge, dbg_rdata<=ram_rdata if the granted access was a read; unchanged for a write.
  - Next state S_DBG_ACK.
- S_DBG_ACK:
  - dbg_ack=1, which is registered and decoded from state.
  - CPU owns the RAM.
  - Next state S_CPU.
- Loader rules:
  - dbg_req is ignored in S_DBG_RD and S_DBG_ACK.
  - The requester drops dbg_req in the cycle after seeing ack, so the minimum loader turnaround is 4 cycles.
- Latency:
  - CPU: zero added; rdata arrives one cycle after the address, as with the bare RAM.
  - Loader, CPU idle: ack 2 cycles after the grant cycle.
  - Loader, CPU continuously busy: grant after MAX_WAIT blocked cycles, then ack 2 cycles later.
- Stalled CPU cycle: cpu_rdata in the following cycle carries loader data. The pipeline holds on cpu_stall and re-reads on retry; the arbiter does not mask it.
- Simultaneous CPU and loader write, same address:
  - Under dbg_sel=0 only the CPU write occurs.
  - Under a forced grant only the loader write occurs; the CPU retries next cycle and overwrites.
- dbg_req dropped mid-transaction (protocol violation): the transaction completes and ack still pulses.
- Reset mid-operation: an async return to S_CPU aborts any pending ack. A write already issued stays written. A still-held dbg_req is re-arbitrated after reset.

Decomposition:
- Shared package dmem_pkg:
  - state typedef/localparams (S_CPU, S_DBG_RD, S_DBG_ACK)
  - DMEM_ADDR_W=14, DMEM_DATA_W=32
  - DMEM_MAX_WAIT default
- Single module. The wait counter and grant logic are small enough that no sub-module is warranted.

Test Plan:
1. CPU idle. Loader writes 0xDEADBEEF to addr 0x0010, then reads 0x0010 -> ram_we pulses in grant cycle; dbg_ack at grant+2 each time; second dbg_rdata=0xDEADBEEF.
2. CPU continuous loads at 0x0000..0x0007, dbg_req read held from cycle 0, MAX_WAIT=4 -> cpu_stall=1 exactly once at cycle 4; ram_addr=dbg_addr that cycle; dbg_ack at cycle 6; CPU never stalled otherwise.
3. CPU store 0x11111111 and loader write 0x22222222 to 0x0020, CPU busy then idle -> CPU write first; loader write after CPU idles; final read of 0x0020 = 0x22222222.
4. Loader read granted, cpu_req=1 during S_DBG_RD and S_DBG_ACK -> cpu_stall=0 in both; ram_addr=cpu_addr; CPU store lands.
5. rst pulsed in S_DBG_RD with dbg_req held -> outputs return to reset values immediately; no dbg_ack during reset; request re-granted and acked after release.
6. dbg_req held high through ack (violation) -> no re-grant while in S_DBG_RD/S_DBG_ACK; a new grant is permitted only from S_CPU.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, loader wait bound and arbiter state encoding for the data-RAM arbiter
package dmem_pkg;
  localparam int DMEM_ADDR_W = 14;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_MAX_WAIT = 4;
  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_DBG_RD  = 2'd1,
    S_DBG_ACK = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU-priority arbiter for the MEM-stage data RAM with a starvation-bounded loader port
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int MAX_WAIT = DMEM_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_t     state;
  logic [3:0] wait_cnt;
  logic       dbg_rd;
  logic       dbg_sel;
  // gated by rst so a held loader request cannot reach the RAM during reset
  assign dbg_sel   = !rst && state == S_CPU && dbg_req && (!cpu_req || wait_cnt == 4'(MAX_WAIT));
  assign ram_addr  = dbg_sel ? dbg_addr : cpu_addr;
  assign ram_wdata = dbg_sel ? dbg_wdata : cpu_wdata;
  assign ram_we    = !rst && (dbg_sel ? dbg_we : cpu_req && cpu_we);
  assign cpu_stall = dbg_sel && cpu_req;
  assign cpu_rdata = ram_rdata;
  assign dbg_ack   = state == S_DBG_ACK;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_CPU;
      wait_cnt  <= '0;
      dbg_rd    <= 1'b0;
      dbg_rdata <= '0;
    end else
      case (state)
        S_CPU: begin
          if (dbg_sel) begin
            state    <= S_DBG_RD;
            wait_cnt <= '0;
            dbg_rd   <= !dbg_we;
          end else
            wait_cnt <= !dbg_req ? '0 : (cpu_req && wait_cnt != 4'(MAX_WAIT)) ? wait_cnt + 4'd1 : wait_cnt;
        end
        S_DBG_RD: begin
          if (dbg_rd) dbg_rdata <= ram_rdata;
          state <= S_DBG_ACK;
        end
        default: state <= S_CPU;
      endcase
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of CPU priority, loader handshake, forced grant and reset abort
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [13:0] dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [0:255];
  int tot = 0, pass_n = 0, fail_n = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic cpu(input logic r, input logic w, input logic [13:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dbg(input logic r, input logic w, input logic [13:0] a, input logic [31:0] d);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
  endtask

  initial begin
    nxt;
    mid;
    chk("rst_ack", dbg_ack, 1'b0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    cpu(1, 1, 14'h5, 32'h1);
    dbg(1, 1, 14'h6, 32'h2);
    mid;
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_we", ram_we, 1'b0);
    nxt;
    cpu(0, 0, 14'h0, 32'h0);
    dbg(0, 0, 14'h0, 32'h0);
    rst = 1'b0;
    nxt;
    // loader write then read-back with the CPU idle
    dbg(1, 1, 14'h10, 32'hDEADBEEF);
    mid;
    chk("t1_grant_we", ram_we, 1'b1);
    chk("t1_grant_addr", ram_addr, 14'h10);
    chk("t1_grant_wdata", ram_wdata, 32'hDEADBEEF);
    chk("t1_grant_ack", dbg_ack, 1'b0);
    nxt;
    mid;
    chk("t1_rd_we", ram_we, 1'b0);
    chk("t1_rd_ack", dbg_ack, 1'b0);
    nxt;
    mid;
    chk("t1_wr_ack", dbg_ack, 1'b1);
    nxt;
    dbg(0, 0, 14'h0, 32'h0);
    mid;
    chk("t1_idle_ack", dbg_ack, 1'b0);
    nxt;
    dbg(1, 0, 14'h10, 32'h0);
    mid;
    chk("t1_rdgrant_we", ram_we, 1'b0);
    chk("t1_rdgrant_addr", ram_addr, 14'h10);
    nxt;
    mid;
    nxt;
    mid;
    chk("t1_rd_ack2", dbg_ack, 1'b1);
    chk("t1_rd_data", dbg_rdata, 32'hDEADBEEF);
    nxt;
    dbg(0, 0, 14'h0, 32'h0);
    nxt;
    // CPU busy every cycle: loader forced in once after MAX_WAIT blocked cycles
    dbg(1, 0, 14'h10, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cpu(1, 0, 14'(i), 32'h0);
      mid;
      chk("t2_stall", cpu_stall, 1'(i == 4));
      if (i == 4) chk("t2_forced_addr", ram_addr, 14'h10);
      if (i != 4) chk("t2_cpu_addr", ram_addr, 14'(i));
      chk("t2_ack", dbg_ack, 1'(i == 6));
      nxt;
      if (i == 6) dbg(0, 0, 14'h0, 32'h0);
    end
    cpu(0, 0, 14'h0, 32'h0);
    nxt;
    // same-address writes: CPU wins while busy, loader lands once CPU idles
    cpu(1, 1, 14'h20, 32'h11111111);
    dbg(1, 1, 14'h20, 32'h22222222);
    mid;
    chk("t3_cpu_we", ram_we, 1'b1);
    chk("t3_cpu_wdata", ram_wdata, 32'h11111111);
    chk("t3_cpu_stall", cpu_stall, 1'b0);
    nxt;
    cpu(0, 0, 14'h0, 32'h0);
    mid;
    chk("t3_dbg_we", ram_we, 1'b1);
    chk("t3_dbg_addr", ram_addr, 14'h20);
    chk("t3_dbg_wdata", ram_wdata, 32'h22222222);
    nxt;
    mid;
    nxt;
    mid;
    chk("t3_ack", dbg_ack, 1'b1);
    nxt;
    dbg(0, 0, 14'h0, 32'h0);
    nxt;
    // loader read-back while the CPU stores during RD and ACK
    dbg(1, 0, 14'h20, 32'h0);
    mid;
    chk("t4_grant_addr", ram_addr, 14'h20);
    nxt;
    cpu(1, 1, 14'h30, 32'h33333333);
    mid;
    chk("t4_rd_stall", cpu_stall, 1'b0);
    chk("t4_rd_addr", ram_addr, 14'h30);
    chk("t4_rd_we", ram_we, 1'b1);
    chk("t4_cpu_rdata", cpu_rdata, 32'h22222222);
    nxt;
    cpu(1, 1, 14'h31, 32'h44444444);
    mid;
    chk("t4_ack_stall", cpu_stall, 1'b0);
    chk("t4_ack_addr", ram_addr, 14'h31);
    chk("t4_ack", dbg_ack, 1'b1);
    chk("t3_final", dbg_rdata, 32'h22222222);
    nxt;
    cpu(0, 0, 14'h0, 32'h0);
    dbg(0, 0, 14'h0, 32'h0);
    mid;
    chk("t4_mem30", mem[8'h30], 32'h33333333);
    chk("t4_mem31", mem[8'h31], 32'h44444444);
    nxt;
    // async reset in S_DBG_RD with the request still held
    dbg(1, 1, 14'h40, 32'h55);
    mid;
    chk("t5_grant_we", ram_we, 1'b1);
    nxt;
    rst = 1'b1;
    #1;
    chk("t5_rst_ack", dbg_ack, 1'b0);
    chk("t5_rst_we", ram_we, 1'b0);
    chk("t5_rst_rdata", dbg_rdata, 32'h0);
    mid;
    chk("t5_mem40", mem[8'h40], 32'h55);
    nxt;
    mid;
    chk("t5_no_ack", dbg_ack, 1'b0);
    nxt;
    rst = 1'b0;
    mid;
    chk("t5_regrant_we", ram_we, 1'b1);
    chk("t5_regrant_addr", ram_addr, 14'h40);
    nxt;
    mid;
    nxt;
    mid;
    chk("t5_ack", dbg_ack, 1'b1);
    nxt;
    dbg(0, 0, 14'h0, 32'h0);
    nxt;
    // request held through ack: ignored in RD/ACK, re-granted only from S_CPU
    cpu(0, 0, 14'h7, 32'h0);
    dbg(1, 0, 14'h10, 32'h0);
    mid;
    chk("t6_grant_addr", ram_addr, 14'h10);
    nxt;
    mid;
    chk("t6_rd_addr", ram_addr, 14'h7);
    chk("t6_rd_ack", dbg_ack, 1'b0);
    nxt;
    mid;
    chk("t6_ack_addr", ram_addr, 14'h7);
    chk("t6_ack", dbg_ack, 1'b1);
    nxt;
    mid;
    chk("t6_regrant_addr", ram_addr, 14'h10);
    chk("t6_regrant_ack", dbg_ack, 1'b0);
    nxt;
    mid;
    nxt;
    mid;
    chk("t6_ack2", dbg_ack, 1'b1);
    nxt;
    dbg(0, 0, 14'h0, 32'h0);
    mid;
    chk("t6_idle_addr", ram_addr, 14'h7);
    chk("t6_idle_ack", dbg_ack, 1'b0);
    nxt;
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
